// File: rtl/conv_seq_ctrl.sv
// conv_seq_ctrl -- sequencer for a sliding-window convolution engine.
//
// Loads X_LEN samples into an external x memory and F_LEN taps into an
// external f memory (both with 1-cycle synchronous read), then walks the
// Y_LEN = X_LEN-F_LEN+1 output windows. For each window the MAC accumulator
// is cleared, fed F_LEN products, and the finished result is offered
// downstream with a valid/ready handshake.
//
// Build option: CONV_FILTER_KEEP_EN -- when defined, taps are loaded only
// once after reset and reused by every later frame.
//
// Ports
//   clk        clock, all state on rising edge
//   reset      asynchronous reset, active low
//   x_valid/x_ready   x sample load handshake
//   f_valid/f_ready   filter tap load handshake
//   y_valid/y_ready   finished-output handshake, y_last marks last of frame
//   addr_x, wr_en_x   x memory address / write strobe
//   addr_f, wr_en_f   f memory address / write strobe
//   clear_acc  zero the MAC accumulator
//   en_acc     accumulate the current memory read data
//
// state   | meaning
// S_LOAD  | accepting x samples and f taps until both memories are full
// S_COMPUTE | issuing F_LEN reads for output j, accumulator fed one cycle later
// S_HOLD  | output j complete, y_valid held until downstream accepts

module conv_seq_ctrl #(
  parameter int X_LEN = 12,
  parameter int F_LEN = 5,
  localparam int Y_LEN = X_LEN - F_LEN + 1,
  localparam int AX    = $clog2(X_LEN),
  localparam int AF    = $clog2(F_LEN),
  localparam int AXW   = (AX > 0) ? AX : 1,
  localparam int AFW   = (AF > 0) ? AF : 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           x_valid,
  output logic           x_ready,
  input  logic           f_valid,
  output logic           f_ready,
  input  logic           y_ready,
  output logic           y_valid,
  output logic           y_last,
  output logic [AXW-1:0] addr_x,
  output logic           wr_en_x,
  output logic [AFW-1:0] addr_f,
  output logic           wr_en_f,
  output logic           clear_acc,
  output logic           en_acc
);

  localparam int CXW = $clog2(X_LEN + 1);
  localparam int CFW = $clog2(F_LEN + 1);
  localparam int JW  = (Y_LEN > 1) ? $clog2(Y_LEN) : 1;

  localparam logic [CXW-1:0] X_FULL = CXW'(X_LEN);
  localparam logic [CXW-1:0] X_TOP  = CXW'(X_LEN - 1);
  localparam logic [CFW-1:0] F_FULL = CFW'(F_LEN);
  localparam logic [CFW-1:0] F_TOP  = CFW'(F_LEN - 1);
  localparam logic [JW-1:0]  J_LAST = JW'(Y_LEN - 1);

`ifdef CONV_FILTER_KEEP_EN
  localparam bit KEEP_TAPS = 1'b1;
`else
  localparam bit KEEP_TAPS = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_LOAD    = 2'd0,
    S_COMPUTE = 2'd1,
    S_HOLD    = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [CXW-1:0] x_cnt_q, x_cnt_d;
  logic [CFW-1:0] f_cnt_q, f_cnt_d;
  logic [CFW-1:0] c_q, c_d;
  logic [JW-1:0]  j_q, j_d;
  logic           run_q;
  logic           en_q;
  logic           issue;
  logic [CFW-1:0] c_sat;
  logic [CXW-1:0] ax_load;
  logic [CFW-1:0] af_load;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_LOAD;
      x_cnt_q <= '0;
      f_cnt_q <= '0;
      c_q     <= '0;
      j_q     <= '0;
      run_q   <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      x_cnt_q <= x_cnt_d;
      f_cnt_q <= f_cnt_d;
      c_q     <= c_d;
      j_q     <= j_d;
      run_q   <= 1'b1;
      en_q    <= issue;
    end
  end

  always_comb begin
    state_d   = state_q;
    x_cnt_d   = x_cnt_q;
    f_cnt_d   = f_cnt_q;
    c_d       = c_q;
    j_d       = j_q;
    x_ready   = 1'b0;
    f_ready   = 1'b0;
    wr_en_x   = 1'b0;
    wr_en_f   = 1'b0;
    clear_acc = 1'b0;
    y_valid   = 1'b0;
    issue     = 1'b0;

    // c_q parks at F_LEN for the drain cycle and HOLD; addresses keep the
    // last issued tap so they stay stable while the result is offered.
    c_sat   = (c_q == F_FULL) ? F_TOP : c_q;
    ax_load = (x_cnt_q == X_FULL) ? X_TOP : x_cnt_q;
    af_load = (f_cnt_q == F_FULL) ? F_TOP : f_cnt_q;
    addr_x  = AXW'(CXW'(j_q) + CXW'(c_sat));
    addr_f  = AFW'(c_sat);

    case (state_q)
      S_LOAD: begin
        addr_x  = AXW'(ax_load);
        addr_f  = AFW'(af_load);
        x_ready = run_q && (x_cnt_q != X_FULL);
        f_ready = run_q && (f_cnt_q != F_FULL);
        wr_en_x = x_valid && x_ready;
        wr_en_f = f_valid && f_ready;
        if (wr_en_x) x_cnt_d = x_cnt_q + CXW'(1);
        if (wr_en_f) f_cnt_d = f_cnt_q + CFW'(1);
        if ((x_cnt_q == X_FULL) && (f_cnt_q == F_FULL)) begin
          state_d = S_COMPUTE;
          c_d     = '0;
        end
      end
      S_COMPUTE: begin
        clear_acc = (c_q == '0);
        issue     = (c_q != F_FULL);
        if (issue) c_d = c_q + CFW'(1);
        else       state_d = S_HOLD;
      end
      S_HOLD: begin
        y_valid = 1'b1;
        if (y_ready) begin
          c_d = '0;
          if (j_q != J_LAST) begin
            j_d     = j_q + JW'(1);
            state_d = S_COMPUTE;
          end else begin
            j_d     = '0;
            x_cnt_d = '0;
            f_cnt_d = KEEP_TAPS ? f_cnt_q : '0;
            state_d = S_LOAD;
          end
        end
      end
      default: begin
        state_d = S_LOAD;
      end
    endcase
  end

  assign en_acc = en_q;
  assign y_last = y_valid && (j_q == J_LAST);

endmodule

// File: tb/tb_conv_seq_ctrl.sv
module tb_conv_seq_ctrl;

`ifdef CONV_FILTER_KEEP_EN
  localparam bit KEEP = 1'b1;
`else
  localparam bit KEEP = 1'b0;
`endif

  localparam int XL = 12;
  localparam int FL = 5;
  localparam int YL = XL - FL + 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // main instance (12 samples, 5 taps)
  logic x_valid = 0, f_valid = 0, y_ready = 0;
  logic x_ready, f_ready, y_valid, y_last, wr_en_x, wr_en_f, clear_acc, en_acc;
  logic [3:0] addr_x;
  logic [2:0] addr_f;

  conv_seq_ctrl #(.X_LEN(XL), .F_LEN(FL)) dut (
    .clk(clk), .reset(reset),
    .x_valid(x_valid), .x_ready(x_ready),
    .f_valid(f_valid), .f_ready(f_ready),
    .y_ready(y_ready), .y_valid(y_valid), .y_last(y_last),
    .addr_x(addr_x), .wr_en_x(wr_en_x),
    .addr_f(addr_f), .wr_en_f(wr_en_f),
    .clear_acc(clear_acc), .en_acc(en_acc)
  );

  // small instance (4 samples, 1 tap)
  logic s_x_valid = 0, s_f_valid = 0, s_y_ready = 0;
  logic s_x_ready, s_f_ready, s_y_valid, s_y_last, s_wr_en_x, s_wr_en_f, s_clear_acc, s_en_acc;
  logic [1:0] s_addr_x;
  logic [0:0] s_addr_f;

  conv_seq_ctrl #(.X_LEN(4), .F_LEN(1)) dut_s (
    .clk(clk), .reset(reset),
    .x_valid(s_x_valid), .x_ready(s_x_ready),
    .f_valid(s_f_valid), .f_ready(s_f_ready),
    .y_ready(s_y_ready), .y_valid(s_y_valid), .y_last(s_y_last),
    .addr_x(s_addr_x), .wr_en_x(s_wr_en_x),
    .addr_f(s_addr_f), .wr_en_f(s_wr_en_f),
    .clear_acc(s_clear_acc), .en_acc(s_en_acc)
  );

  // external memories + MAC model for the main instance
  int xs[16];
  int fs[8];
  int xmem[16];
  int fmem[8];
  int rdx, rdf, acc;

  always @(posedge clk) begin
    if (wr_en_x) xmem[addr_x] <= xs[addr_x];
    if (wr_en_f) fmem[addr_f] <= fs[addr_f];
    rdx <= xmem[addr_x];
    rdf <= fmem[addr_f];
    if (clear_acc)   acc <= 0;
    else if (en_acc) acc <= acc + rdx * rdf;
  end

  function automatic int exp_y(input int j);
    int s = 0;
    for (int c = 0; c < FL; c++) s += xs[j + c] * fs[c];
    return s;
  endfunction

  int nchecks = 0;
  int nerr = 0;

  task automatic check(input string name, input int act, input int exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int pack(input int xr, fr, wx, wf, ax, af, clr, en, yv, yl);
    return (xr << 10) | (fr << 9) | (wx << 8) | (wf << 7) | (ax << 5) |
           (af << 4) | (clr << 3) | (en << 2) | (yv << 1) | yl;
  endfunction

  typedef struct {
    int xv, fv, yr;
    int xr, fr, wx, wf, ax, af, clr, en, yv, yl;
  } vec_t;

  vec_t tv[21];

  task automatic start_reset();
    reset = 0;
    x_valid = 0; f_valid = 0; y_ready = 0;
    s_x_valid = 0; s_f_valid = 0; s_y_ready = 0;
    repeat (2) @(posedge clk);
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1;
    #1;
    check("ready gated before first edge", int'({x_ready, f_ready}), 0);
  endtask

  task automatic run_frame(input string tag, input int x_stall_at, input int x_stall_len,
                           input int y_stall_j, input int y_stall_len,
                           input int exp_fw, input int abort_j);
    int xw = 0, fw = 0, yv_cnt = 0, cyc = 0, stall = 0, ystall = 0;
    int clr_cyc = -100, last_xw_cyc = -1, first_xw_cyc = -1, first_clr_cyc = -1;
    int early = 0, bad_dist = 0, bad_acc = 0, bad_last = 0, bad_hold = 0, bad_restart = 0;
    logic prev_yv = 0, prev_hs = 0;
    logic [3:0] hold_ax = '0;
    logic [2:0] hold_af = '0;
    bit done = 0;
    while (!done && cyc < 3000) begin
      @(negedge clk);
      x_valid = !(xw == x_stall_at && stall < x_stall_len);
      if (!x_valid) stall++;
      f_valid = 1;
      y_ready = !(y_valid && yv_cnt == y_stall_j && ystall < y_stall_len);
      if (!y_ready) ystall++;
      #1;
      if (abort_j >= 0 && y_valid && yv_cnt == abort_j) begin
        reset = 0;
        #1;
        check({tag, " outputs zero in reset"},
              int'({x_ready, f_ready, wr_en_x, wr_en_f, clear_acc, en_acc,
                    y_valid, y_last, addr_x, addr_f}), 0);
        return;
      end
      if (wr_en_x) begin
        xw++;
        last_xw_cyc = cyc;
        if (first_xw_cyc < 0) first_xw_cyc = cyc;
      end
      if (wr_en_f) fw++;
      if ((clear_acc || en_acc) && xw < XL) early++;
      if (clear_acc) begin
        clr_cyc = cyc;
        if (first_clr_cyc < 0) first_clr_cyc = cyc;
      end
      if (prev_hs && (!clear_acc || y_valid)) bad_restart++;
      if (y_valid && !prev_yv) begin
        if (cyc - clr_cyc != FL + 1) bad_dist++;
        hold_ax = addr_x;
        hold_af = addr_f;
      end
      if (y_valid && (addr_x != hold_ax || addr_f != hold_af || en_acc || clear_acc)) bad_hold++;
      if (y_last && !y_valid) bad_last++;
      prev_yv = y_valid;
      prev_hs = y_valid && y_ready;
      if (y_valid && y_ready) begin
        if (acc != exp_y(yv_cnt)) begin
          bad_acc++;
          $display("FAIL %s y%0d value: got %0d expected %0d", tag, yv_cnt, acc, exp_y(yv_cnt));
        end
        if (y_last != (yv_cnt == YL - 1)) bad_last++;
        yv_cnt++;
        if (yv_cnt == YL) begin
          done = 1;
          prev_hs = 0;
        end
      end
      cyc++;
    end
    check({tag, " outputs delivered"}, yv_cnt, YL);
    check({tag, " x writes"}, xw, XL);
    check({tag, " f writes"}, fw, exp_fw);
    check({tag, " first x write cycle"}, first_xw_cyc, 0);
    check({tag, " compute start latency"}, first_clr_cyc - last_xw_cyc, 2);
    check({tag, " acc activity before load done"}, early, 0);
    check({tag, " clear to y_valid distance"}, bad_dist, 0);
    check({tag, " y values"}, bad_acc, 0);
    check({tag, " y_last placement"}, bad_last, 0);
    check({tag, " hold stability"}, bad_hold, 0);
    check({tag, " restart after handshake"}, bad_restart, 0);
    @(negedge clk);
    x_valid = 0;
    f_valid = 0;
    y_ready = 0;
    #1;
    check({tag, " x_ready after frame"}, int'(x_ready), 1);
    check({tag, " f_ready after frame"}, int'(f_ready), int'(!KEEP));
  endtask

  initial begin
    tv[0]  = '{1,1,1, 0,0,0,0,0,0,0,0,0,0};
    tv[1]  = '{1,0,1, 1,1,1,0,0,0,0,0,0,0};
    tv[2]  = '{0,1,1, 1,1,0,1,1,0,0,0,0,0};
    tv[3]  = '{1,1,1, 1,0,1,0,1,0,0,0,0,0};
    tv[4]  = '{1,0,1, 1,0,1,0,2,0,0,0,0,0};
    tv[5]  = '{1,1,1, 1,0,1,0,3,0,0,0,0,0};
    tv[6]  = '{1,1,1, 0,0,0,0,3,0,0,0,0,0};
    tv[7]  = '{1,1,1, 0,0,0,0,0,0,1,0,0,0};
    tv[8]  = '{1,1,1, 0,0,0,0,0,0,0,1,0,0};
    tv[9]  = '{0,0,1, 0,0,0,0,0,0,0,0,1,0};
    tv[10] = '{1,1,0, 0,0,0,0,1,0,1,0,0,0};
    tv[11] = '{1,1,0, 0,0,0,0,1,0,0,1,0,0};
    tv[12] = '{0,0,0, 0,0,0,0,1,0,0,0,1,0};
    tv[13] = '{0,0,1, 0,0,0,0,1,0,0,0,1,0};
    tv[14] = '{1,1,1, 0,0,0,0,2,0,1,0,0,0};
    tv[15] = '{1,1,1, 0,0,0,0,2,0,0,1,0,0};
    tv[16] = '{0,0,1, 0,0,0,0,2,0,0,0,1,0};
    tv[17] = '{1,1,1, 0,0,0,0,3,0,1,0,0,0};
    tv[18] = '{1,1,1, 0,0,0,0,3,0,0,1,0,0};
    tv[19] = '{0,0,1, 0,0,0,0,3,0,0,0,1,1};
    tv[20] = '{0,0,0, 1,int'(!KEEP),0,0,0,0,0,0,0,0};

    for (int c = 0; c < 8; c++) fs[c] = 0;
    fs[0] = 3; fs[1] = -1; fs[2] = 4; fs[3] = 1; fs[4] = -5;

    // small instance, cycle-by-cycle table over one whole frame
    start_reset();
    release_reset();
    for (int i = 0; i < 21; i++) begin
      if (i > 0) @(negedge clk);
      s_x_valid = tv[i].xv[0];
      s_f_valid = tv[i].fv[0];
      s_y_ready = tv[i].yr[0];
      #1;
      check($sformatf("small vec%0d", i),
            pack(int'(s_x_ready), int'(s_f_ready), int'(s_wr_en_x), int'(s_wr_en_f),
                 int'(s_addr_x), int'(s_addr_f), int'(s_clear_acc), int'(s_en_acc),
                 int'(s_y_valid), int'(s_y_last)),
            pack(tv[i].xr, tv[i].fr, tv[i].wx, tv[i].wf, tv[i].ax, tv[i].af,
                 tv[i].clr, tv[i].en, tv[i].yv, tv[i].yl));
    end
    s_x_valid = 0; s_f_valid = 0; s_y_ready = 0;

    // frame A: everything streaming
    for (int i = 0; i < 16; i++) xs[i] = (i * 7 + 3) % 13 - 4;
    start_reset();
    release_reset();
    run_frame("A", -1, 0, -1, 0, FL, -1);

    // frame B: x stalled after 7 samples, output 3 back-pressured
    for (int i = 0; i < 16; i++) xs[i] = (i * 5 + 1) % 11 - 2;
    run_frame("B", 7, 20, 3, 10, KEEP ? 0 : FL, -1);

    // frame C: reset while output 5 is held, then frame D reloads everything
    for (int i = 0; i < 16; i++) xs[i] = (i * 3 + 2) % 9;
    run_frame("C", -1, 0, 5, 4, KEEP ? 0 : FL, 5);
    repeat (2) @(posedge clk);
    release_reset();
    for (int i = 0; i < 16; i++) xs[i] = 10 - (i * 4) % 17;
    run_frame("D", -1, 0, -1, 0, FL, -1);

    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

endmodule

// File: doc/conv_seq_ctrl.md
CONV_SEQ_CTRL -- requirements
Module: conv_seq_ctrl

Interface
REQ-001 SHALL have parameter X_LEN, default 12, number of x samples per frame.
REQ-002 SHALL have parameter F_LEN, default 5, number of filter taps per frame (1 <= F_LEN <= X_LEN).
REQ-003 SHALL define Y_LEN = X_LEN-F_LEN+1 (outputs per frame), AX = $clog2(X_LEN), AF = $clog2(F_LEN).
REQ-004 SHALL have ports:
 clk  in  1  single clock, all state on rising edge
 reset  in  1  asynchronous, active-low reset
 x_valid  in  1  x input data valid
 x_ready  out  1  controller accepts x sample
 f_valid  in  1  filter tap valid
 f_ready  out  1  controller accepts filter tap
 y_ready  in  1  downstream accepts output
 y_valid  out  1  accumulator holds a finished output
 y_last  out  1  current y_valid is last of frame
 addr_x  out  AX  x memory address (write and read)
 wr_en_x  out  1  x memory write strobe
 addr_f  out  AF  f memory address (write and read)
 wr_en_f  out  1  f memory write strobe
 clear_acc  out  1  zero MAC accumulator
 en_acc  out  1  accumulate current memory outputs

Function
REQ-005 SHALL implement FSM states LOAD, COMPUTE, HOLD; external memories have 1-cycle synchronous read, MAC accumulator is registered (acc <= clear ? 0 : en ? acc+x*f : acc).
REQ-006 LOAD: x_ready = (x_cnt < X_LEN), f_ready = (f_cnt < F_LEN); x and f load concurrently and independently.
REQ-007 LOAD: wr_en_x = x_valid & x_ready, addr_x = x_cnt, x_cnt increments on each write; same rule for f with f_cnt.
REQ-008 LOAD -> COMPUTE on the edge after x_cnt == X_LEN and f_cnt == F_LEN both hold; order of completion irrelevant.
REQ-009 COMPUTE for output j (0..Y_LEN-1), cycle c = 0..F_LEN-1: addr_f = c, addr_x = j+c, wr_en_x = wr_en_f = 0.
REQ-010 clear_acc SHALL be 1 exactly in cycle c = 0 of each output, 0 otherwise (after reset).
REQ-011 en_acc SHALL be the 1-cycle-delayed issue strobe: high for cycles 1..F_LEN of each output, never coincident with clear_acc of the same output.
REQ-012 COMPUTE -> HOLD after last en_acc; y_valid SHALL rise F_LEN+1 cycles after clear_acc of that output.
REQ-013 HOLD: y_valid held 1, addresses stable, en_acc = clear_acc = 0 until y_valid & y_ready.
REQ-014 On handshake with j < Y_LEN-1: y_valid drops next cycle, COMPUTE restarts with j+1, clear_acc in that same next cycle.
REQ-015 On handshake with j == Y_LEN-1: return to LOAD, x_cnt/f_cnt/j cleared, x_ready/f_ready high next cycle.
REQ-016 y_last = y_valid & (j == Y_LEN-1).
REQ-017 y_ready while y_valid = 0 SHALL be ignored; x_valid/f_valid outside LOAD or when counter full SHALL be ignored (no write, no count).
REQ-018 Counters SHALL saturate, never wrap; addr_x never exceeds X_LEN-1, addr_f never exceeds F_LEN-1.

Reset
REQ-019 Asserted reset (low), at any time including mid-COMPUTE/HOLD: state LOAD, all counters 0, all outputs 0.
REQ-020 x_ready/f_ready SHALL be gated by a run flag cleared by reset and set on first clk edge after deassertion; first load accepted in cycle 1 after release.
REQ-021 Memory contents are not cleared; a frame interrupted by reset SHALL be fully reloaded.

Configuration
REQ-022 Macro CONV_FILTER_KEEP_EN: when defined, after the first frame completes f_cnt stays at F_LEN, f_ready stays 0, and later frames load only x using retained taps until reset.
REQ-023 Without CONV_FILTER_KEEP_EN, every frame reloads all F_LEN taps per REQ-006/REQ-015.

Verification
REQ-024 Reset release, x_valid=f_valid=1 continuously, y_ready=1 -> 12 x writes, 5 f writes, 8 y_valid pulses, y_last only on 8th, x_ready high again.
REQ-025 f loaded fully, x stalled after 7 samples for 20 cycles -> no clear_acc/en_acc until 12th x write; COMPUTE starts edge after.
REQ-026 y_ready=0 for 10 cycles at output 3 -> y_valid held, addr_x/addr_f stable, en_acc=0, then output 4 clear_acc cycle after handshake.
REQ-027 Reset low in HOLD of output 5 -> all outputs 0 immediately; after release full 12+5 reload required before any y_valid.
REQ-028 CONV_FILTER_KEEP_EN defined, two frames -> second frame f_ready stays 0, only 12 x writes, 8 outputs with addr_f 0..4 per output.
REQ-029 F_LEN=1, X_LEN=4 build -> 4 outputs, y_valid 2 cycles after each clear_acc.
